// File: rtl/multi_freq_divider_pkg.sv
// Shared types for the SIMPS clock/tick divider: output mode, channel
// configuration record and the channel-select width helper.
package simps_clk_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic {
    DIV_TOGGLE = 1'b0,
    DIV_STROBE = 1'b1
  } div_mode_t;

  typedef struct packed {
    logic [DIV_WIDTH-1:0] div;
    div_mode_t            mode;
  } div_cfg_t;

  // A single-channel build still needs a 1-bit select port.
  function automatic int ch_sel_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/multi_freq_divider_channel.sv
// One divider channel: terminal-count counter, active and shadow config,
// and registered div_out/tick outputs.
module freq_div_channel
  import simps_clk_pkg::*;
#(
  parameter int DEFAULT_DIV = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 sync,
  input  logic                 cfg_wr,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  div_mode_t            cfg_mode,
  output logic                 cfg_pending,
  output logic                 div_out,
  output logic                 tick
);

  localparam div_cfg_t RESET_CFG = '{div: DIV_WIDTH'(DEFAULT_DIV), mode: DIV_TOGGLE};

  div_cfg_t             active_q, active_d;
  div_cfg_t             shadow_q, shadow_d;
  div_cfg_t             wr_cfg, next_cfg;
  logic [DIV_WIDTH-1:0] count_q, count_d;
  logic                 pending_q, pending_d;
  logic                 div_out_q, div_out_d;
  logic                 tick_q, tick_d;
  logic                 tc;

  assign wr_cfg = '{div: cfg_div, mode: cfg_mode};
  assign tc     = (count_q == active_q.div);

  always_comb begin
    // NOTE: every next-state value defaults to hold first, so no path through
    // the branches below can infer a latch.
    count_d   = count_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    div_out_d = div_out_q;
    tick_d    = 1'b0;
    next_cfg  = active_q;

    if (sync) begin
      // Realign to phase 0; a write in this same cycle wins over an older shadow.
      count_d   = '0;
      div_out_d = 1'b0;
      pending_d = 1'b0;
      if (cfg_wr)         active_d = wr_cfg;
      else if (pending_q) active_d = shadow_q;
    end else if (!en) begin
      if (active_q.mode == DIV_STROBE) div_out_d = 1'b0;
      if (cfg_wr) begin
        active_d  = wr_cfg;
        pending_d = 1'b0;
        count_d   = '0;
        if (wr_cfg.mode != active_q.mode) div_out_d = 1'b0;
      end
    end else if (tc) begin
      // The TC applies the shadow held before this edge; a concurrent write
      // becomes the next pending shadow.
      count_d   = '0;
      tick_d    = 1'b1;
      next_cfg  = pending_q ? shadow_q : active_q;
      active_d  = next_cfg;
      pending_d = 1'b0;
      if (next_cfg.mode != active_q.mode)  div_out_d = 1'b0;
      else if (active_q.mode == DIV_TOGGLE) div_out_d = ~div_out_q;
      else                                  div_out_d = 1'b1;
      if (cfg_wr) begin
        shadow_d  = wr_cfg;
        pending_d = 1'b1;
      end
    end else begin
      count_d = count_q + 1'b1;
      if (active_q.mode == DIV_STROBE) div_out_d = 1'b0;
      if (cfg_wr) begin
        shadow_d  = wr_cfg;
        pending_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      active_q  <= RESET_CFG;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      div_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      div_out_q <= div_out_d;
      tick_q    <= tick_d;
    end
  end

  assign cfg_pending = pending_q;
  assign div_out     = div_out_q;
  assign tick        = tick_q;

endmodule

// File: rtl/multi_freq_divider.sv
// N-channel programmable clock/tick divider: decodes config writes to
// per-channel strobes and broadcasts sync to every channel.
module multi_freq_divider
  import simps_clk_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int WIDTH       = DIV_WIDTH,  // must equal simps_clk_pkg::DIV_WIDTH
  parameter int DEFAULT_DIV = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_CH-1:0]                 en,
  input  logic                            sync,
  input  logic                            cfg_wr,
  input  logic [ch_sel_width(N_CH)-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]                cfg_div,
  input  logic                            cfg_mode,
  output logic [N_CH-1:0]                 cfg_pending,
  output logic [N_CH-1:0]                 div_out,
  output logic [N_CH-1:0]                 tick
);

  localparam int CH_W = ch_sel_width(N_CH);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic ch_wr;

    // Out-of-range channel numbers match no instance and are dropped.
    assign ch_wr = cfg_wr && (cfg_ch == CH_W'(g));

    freq_div_channel #(
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .en          (en[g]),
      .sync        (sync),
      .cfg_wr      (ch_wr),
      .cfg_div     (cfg_div),
      .cfg_mode    (div_mode_t'(cfg_mode)),
      .cfg_pending (cfg_pending[g]),
      .div_out     (div_out[g]),
      .tick        (tick[g])
    );
  end

endmodule

// File: tb/tb_multi_freq_divider.sv
// Self-checking bench for multi_freq_divider: directed scenarios followed by
// random traffic, all compared every cycle against a period-level model.
module tb_multi_freq_divider;

  localparam int N_CH = 3;
  localparam int CH_W = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N_CH-1:0] en;
  logic            sync;
  logic            cfg_wr;
  logic [CH_W-1:0] cfg_ch;
  logic [7:0]      cfg_div;
  logic            cfg_mode;
  logic [N_CH-1:0] cfg_pending;
  logic [N_CH-1:0] div_out;
  logic [N_CH-1:0] tick;

  multi_freq_divider #(
    .N_CH        (N_CH),
    .WIDTH       (8),
    .DEFAULT_DIV (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .sync        (sync),
    .cfg_wr      (cfg_wr),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_mode    (cfg_mode),
    .cfg_pending (cfg_pending),
    .div_out     (div_out),
    .tick        (tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: position inside the current period, number of completed periods
  // (the square wave is their parity), divisor/mode, and the shadow request.
  int elapsed [N_CH];
  int periods [N_CH];
  int m_div   [N_CH];
  bit m_mode  [N_CH];
  int sh_div  [N_CH];
  bit sh_mode [N_CH];
  bit m_pend  [N_CH];
  bit m_tick  [N_CH];
  bit quiet   [N_CH];

  task automatic check(input string tag, input int ch, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s ch%0d: got %b expected %b", tag, ch, got, exp);
  endtask

  function automatic bit exp_div_out(input int ch);
    return m_mode[ch] ? (m_tick[ch] && !quiet[ch]) : bit'(periods[ch] % 2);
  endfunction

  function automatic void model_step();
    for (int ch = 0; ch < N_CH; ch++) begin
      bit wr;
      wr = cfg_wr && (int'(cfg_ch) == ch);
      quiet[ch] = 1'b0;
      if (reset) begin
        elapsed[ch] = 0; periods[ch] = 0; m_div[ch] = 2; m_mode[ch] = 1'b0;
        sh_div[ch] = 0; sh_mode[ch] = 1'b0; m_pend[ch] = 1'b0; m_tick[ch] = 1'b0;
      end else if (sync) begin
        if (wr) begin
          m_div[ch] = int'(cfg_div); m_mode[ch] = cfg_mode;
        end else if (m_pend[ch]) begin
          m_div[ch] = sh_div[ch]; m_mode[ch] = sh_mode[ch];
        end
        m_pend[ch] = 1'b0; elapsed[ch] = 0; periods[ch] = 0; m_tick[ch] = 1'b0;
      end else if (!en[ch]) begin
        m_tick[ch] = 1'b0;
        if (wr) begin
          if (cfg_mode != m_mode[ch]) periods[ch] = 0;
          m_div[ch] = int'(cfg_div); m_mode[ch] = cfg_mode;
          m_pend[ch] = 1'b0; elapsed[ch] = 0;
        end
      end else if (elapsed[ch] == m_div[ch]) begin
        m_tick[ch] = 1'b1;
        elapsed[ch] = 0;
        if (m_pend[ch] && sh_mode[ch] != m_mode[ch]) begin
          m_mode[ch] = sh_mode[ch]; m_div[ch] = sh_div[ch];
          periods[ch] = 0; quiet[ch] = 1'b1;
        end else begin
          if (m_pend[ch]) m_div[ch] = sh_div[ch];
          periods[ch]++;
        end
        m_pend[ch] = 1'b0;
        if (wr) begin
          sh_div[ch] = int'(cfg_div); sh_mode[ch] = cfg_mode; m_pend[ch] = 1'b1;
        end
      end else begin
        elapsed[ch]++;
        m_tick[ch] = 1'b0;
        if (wr) begin
          sh_div[ch] = int'(cfg_div); sh_mode[ch] = cfg_mode; m_pend[ch] = 1'b1;
        end
      end
    end
  endfunction

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    for (int ch = 0; ch < N_CH; ch++) begin
      check({tag, ".tick"},    ch, tick[ch],        m_tick[ch]);
      check({tag, ".div_out"}, ch, div_out[ch],     exp_div_out(ch));
      check({tag, ".pending"}, ch, cfg_pending[ch], m_pend[ch]);
    end
  endtask

  task automatic run(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  task automatic write(input int ch, input int d, input bit mode);
    cfg_wr = 1'b1; cfg_ch = CH_W'(ch); cfg_div = 8'(d); cfg_mode = mode;
  endtask

  initial begin
    reset = 1'b1; en = '1; sync = 1'b0;
    cfg_wr = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;

    // Reset held 3 cycles with all channels enabled: everything reads 0.
    run("reset", 3);
    for (int ch = 0; ch < N_CH; ch++) begin
      check("reset_div_out", ch, div_out[ch], 1'b0);
      check("reset_tick",    ch, tick[ch],    1'b0);
      check("reset_pending", ch, cfg_pending[ch], 1'b0);
    end
    reset = 1'b0;

    // Default D=2: first tick after the third edge, then a period-6 square.
    run("first_tick", 2);
    check("tick_not_yet", 0, tick[0], 1'b0);
    step("first_tick");
    check("tick_at_3rd_edge", 0, tick[0], 1'b1);
    run("toggle_d2", 12);

    // ch1 D=4 written mid-period: stays pending until the current TC.
    step("pre_wr");
    write(1, 4, 1'b0);
    step("wr_ch1");
    cfg_wr = 1'b0;
    check("ch1_pending", 1, cfg_pending[1], 1'b1);
    run("ch1_d4", 24);

    // ch2 STROBE D=0: high every cycle; disabling zeroes it and freezes the count.
    write(2, 0, 1'b1);
    step("wr_ch2");
    cfg_wr = 1'b0;
    run("strobe_d0", 8);
    en[2] = 1'b0;
    run("strobe_off", 4);
    en[2] = 1'b1;
    run("strobe_on", 4);

    // ch0 D=2 and ch1 D=5 realigned by sync: ticks coincide every 6 cycles.
    write(0, 2, 1'b0);
    step("wr_ch0");
    write(1, 5, 1'b0);
    step("wr_ch1b");
    cfg_wr = 1'b0;
    sync = 1'b1;
    step("sync");
    sync = 1'b0;
    check("sync_div0", 0, div_out[0], 1'b0);
    check("sync_div1", 1, div_out[1], 1'b0);
    run("aligned", 18);

    // Invalid channel number is ignored; write together with sync applies at once.
    write(3, 9, 1'b1);
    step("bad_ch");
    cfg_wr = 1'b0;
    run("bad_ch_after", 4);
    write(0, 1, 1'b1);
    sync = 1'b1;
    step("wr_sync");
    cfg_wr = 1'b0; sync = 1'b0;
    check("wr_sync_pending", 0, cfg_pending[0], 1'b0);
    run("wr_sync_after", 8);

    // Random traffic: enables, writes, rare syncs and resets.
    for (int k = 0; k < 1500; k++) begin
      reset    = ($urandom_range(0, 299) == 0);
      sync     = ($urandom_range(0, 39) == 0);
      cfg_wr   = ($urandom_range(0, 4) == 0);
      cfg_ch   = CH_W'($urandom_range(0, 3));
      cfg_div  = 8'($urandom_range(0, 6));
      cfg_mode = 1'($urandom_range(0, 1));
      for (int ch = 0; ch < N_CH; ch++) en[ch] = ($urandom_range(0, 7) != 0);
      step("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
